// File: rtl/unified_mem_ctrl_if.sv
// unified_mem_ctrl_if: shared single-port memory bus.
// The controller drives the request side; the memory answers.
interface unified_mem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: fetch/data sequencer over one shared memory.
// Emits one cpu_en commit strobe per instruction.
module unified_mem_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'hE1A00000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc,
  input  logic [31:0]        data_memory_addr,
  input  logic [31:0]        write_data,
  input  logic               mem_write,
  input  logic               mem_read,
  input  logic               halt,
  output logic [31:0]        instr,
  output logic [31:0]        read_data,
  output logic               cpu_en,
  output logic               halted,
  output logic [31:0]        retired,
  unified_mem_ctrl_if.master mem
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_DATA,
    S_COMMIT,
    S_HALT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        req;
  logic        done;
  logic        is_mem;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // request is masked while reset is held so nothing leaks out
  assign mem.mem_req   = req & reset;
  assign mem.mem_we    = (state_q == S_DATA) & we_q;
  assign mem.mem_addr  = (state_q == S_FETCH) ? pc : addr_q;
  assign mem.mem_wdata = wdata_q;

  assign done   = mem.mem_req & mem.mem_ready;
  assign is_mem = mem_write | mem_read;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // next state and state-decoded strobes
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    cpu_en  = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (mem.mem_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_mem) begin
          state_d = S_DATA;
        end else begin
          cpu_en  = 1'b1;
          state_d = halt ? S_HALT : S_FETCH;
        end
      end
      S_DATA: begin
        req = 1'b1;
        if (mem.mem_ready) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        cpu_en  = 1'b1;
        state_d = halt ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (!halt) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // instruction, load data and latched data-request fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr     <= NOP_INSTR;
      read_data <= 32'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
    end else begin
      if (state_q == S_FETCH && done)
        instr <= mem.mem_rdata;
      if (state_q == S_EXEC && is_mem) begin
        addr_q  <= data_memory_addr;
        wdata_q <= write_data;
        we_q    <= mem_write;
      end
      if (state_q == S_DATA && done && !we_q)
        read_data <= mem.mem_rdata;
    end
  end

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      retired <= 32'd0;
    else if (cpu_en) retired <= retired + 32'd1;
  end

endmodule
